alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 47 ++++
 rtl/alu_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of request, shared-ALU and response signals for the two-port ALU arbiter.
// The slave modport is the arbiter side and the master modport is the requester/ALU side.
interface alu_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] alu_reg1;
  logic [WIDTH-1:0] alu_reg2;
  logic [OPW-1:0]   alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             rsp0_valid;
  logic [WIDTH-1:0] rsp0_data;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp1_data;
  logic             rsp1_ready;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output alu_reg1, alu_reg2, alu_ctrl,
    input  alu_result,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  rsp0_ready, rsp1_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  alu_reg1, alu_reg2, alu_ctrl,
    output alu_result,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation takes one IDLE (accept) and one EXEC (capture result) cycle.
module alu_arbiter #(
  parameter int WIDTH      = 8,
  parameter int OPW        = 3,
  parameter int FIRST_PRIO = 0
) (
  input  logic           clk,
  input  logic           reset,
  alu_arbiter_if.slave   bus,
  output logic           busy
);

  typedef enum logic {IDLE, EXEC} state_t;

  // last_q names the requester granted most recently; reset picks the loser
  // so that FIRST_PRIO wins the first contention.
  localparam logic LAST_INIT = (FIRST_PRIO == 0);

  state_t           state_q, state_nxt;
  logic             last_q;
  logic             owner_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;
  logic [WIDTH-1:0] rsp0_data_q;
  logic [WIDTH-1:0] rsp1_data_q;
  logic             elig0, elig1;
  logic             grant0, grant1;

  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    state_nxt = state_q;
    elig0     = bus.req0_valid & ~rsp0_valid_q;
    elig1     = bus.req1_valid & ~rsp1_valid_q;
    case (state_q)
      IDLE: begin
        if (!reset) begin
          if (elig0 && (!elig1 || last_q)) begin
            grant0 = 1'b1;
          end else if (elig1) begin
            grant1 = 1'b1;
          end
        end
        if (grant0 || grant1) begin
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= LAST_INIT;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q <= state_nxt;
      if (grant0) begin
        a_q     <= bus.req0_a;
        b_q     <= bus.req0_b;
        op_q    <= bus.req0_op;
        owner_q <= 1'b0;
        last_q  <= 1'b0;
      end else if (grant1) begin
        a_q     <= bus.req1_a;
        b_q     <= bus.req1_b;
        op_q    <= bus.req1_op;
        owner_q <= 1'b1;
        last_q  <= 1'b1;
      end
      if (rsp0_valid_q && bus.rsp0_ready) rsp0_valid_q <= 1'b0;
      if (rsp1_valid_q && bus.rsp1_ready) rsp1_valid_q <= 1'b0;
      // The owner's buffer was empty at grant, so this set never races its clear.
      if (state_q == EXEC) begin
        if (owner_q == 1'b0) begin
          rsp0_data_q  <= bus.alu_result;
          rsp0_valid_q <= 1'b1;
        end else begin
          rsp1_data_q  <= bus.alu_result;
          rsp1_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.alu_reg1   = a_q;
  assign bus.alu_reg2   = b_q;
  assign bus.alu_ctrl   = op_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp1_data  = rsp1_data_q;
  assign busy           = (state_q == EXEC);

endmodule
